// File: rtl/interp_ups_pkg.sv
// Shared definitions for the zero-stuffing interpolator front end.
//   MAX_LOG2_DEF / WIDTH_DEF / NUM_CH_DEF : default parameter values
//   sat_ratio()  : clamp a requested log2 factor to the largest supported one
//   phase_last() : index of the last phase slot for a given log2 factor
// Build option: INTERP_UPS_HOLD_EN selects zero-order hold instead of zero stuffing
// (used in interp_upsampler_n).
package interp_ups_pkg;

  localparam int MAX_LOG2_DEF = 3;
  localparam int WIDTH_DEF    = 18;
  localparam int NUM_CH_DEF   = 2;

  function automatic int unsigned sat_ratio(input int unsigned sel,
                                            input int unsigned max_log2);
    return (sel > max_log2) ? max_log2 : sel;
  endfunction

  function automatic int unsigned phase_last(input int unsigned log2);
    return (32'd1 << log2) - 32'd1;
  endfunction

endpackage

// File: rtl/ups_fifo2.sv
// Two-entry synchronous FIFO feeding the interpolator.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   i_push / i_wdata  : write request and data (ignored while full, even with a pop)
//   i_pop             : read request (ignored while empty)
//   o_head            : word at the head of the queue (valid when not empty)
//   o_count           : number of stored words, 0..2
//   o_empty / o_full  : decoded from the registered count
// Handshake: a word is taken when i_push is high and o_full is low in the same
// cycle; a word is removed when i_pop is high and o_empty is low.
module ups_fifo2 #(
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // Fullness is judged on the registered count, so a same-cycle pop does not
  // open a slot for a push.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/interp_upsampler_n.sv
// Multi-channel interpolator front end with run-time factor L = 2^ratio_sel.
// Symbol-rate words enter through a 2-deep FIFO; one output slot is produced
// per out_en pulse. Slot 0 of each frame carries a FIFO word (or zero on
// underrun), slots 1..L-1 carry zero, or repeat the slot-0 value when built with
// INTERP_UPS_HOLD_EN (zero-order hold).
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   ratio_sel   : requested log2(L), clamped to MAX_LOG2, sampled at frame start
//   in_valid / in_ready / in_data : input handshake (word taken when both high)
//   out_en      : output-rate enable, one pulse per output slot
//   out_data    : registered output slot (ch0 in LSBs)
//   out_first   : high while out_data holds a slot-0 value
//   underrun    : sticky, set when slot 0 found the FIFO empty
//   clr_flags   : clears underrun (a simultaneous new underrun wins)
module interp_upsampler_n
  import interp_ups_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int NUM_CH   = NUM_CH_DEF,
  parameter  int MAX_LOG2 = MAX_LOG2_DEF,
  localparam int RW       = $clog2(MAX_LOG2 + 1),
  localparam int DW       = WIDTH * NUM_CH,
  localparam int PW       = (MAX_LOG2 > 0) ? MAX_LOG2 : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] ratio_sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          out_en,
  output logic [DW-1:0] out_data,
  output logic          out_first,
  output logic          underrun,
  input  logic          clr_flags
);

  logic [DW-1:0] w_head;
  logic [1:0]    w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_phase0;
  logic          w_pop;
  logic          w_underrun_set;
  logic [RW-1:0] w_sel_sat;
  logic [RW-1:0] w_ratio_eff;
  logic [PW-1:0] w_last;
  logic [PW-1:0] w_phase_next;

  logic [PW-1:0] r_phase;
  logic [RW-1:0] r_ratio;
  logic [DW-1:0] r_out_data;
  logic          r_out_first;
  logic          r_underrun;

  ups_fifo2 #(.DW(DW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign in_ready = ~w_full;

  assign w_sel_sat = RW'(sat_ratio(32'(ratio_sel), MAX_LOG2));
  assign w_phase0  = (r_phase == '0);

  // At a frame start the freshly sampled factor already governs this frame's
  // wrap point; mid-frame the latched factor keeps L stable.
  assign w_ratio_eff  = w_phase0 ? w_sel_sat : r_ratio;
  assign w_last       = PW'(phase_last(32'(w_ratio_eff)));
  assign w_phase_next = (r_phase == w_last) ? '0 : r_phase + PW'(1);

  assign w_pop          = out_en & w_phase0 & ~w_empty;
  assign w_underrun_set = out_en & w_phase0 & w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= '0;
      r_ratio     <= '0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (out_en) begin
        r_phase <= w_phase_next;
        if (w_phase0) begin
          r_ratio     <= w_sel_sat;
          r_out_first <= 1'b1;
          r_out_data  <= w_empty ? '0 : w_head;
        end else begin
          r_out_first <= 1'b0;
`ifdef INTERP_UPS_HOLD_EN
          r_out_data  <= r_out_data;
`else
          r_out_data  <= '0;
`endif
        end
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (clr_flags) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_first = r_out_first;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_interp_upsampler_n.sv
module tb_interp_upsampler_n;
  import interp_ups_pkg::*;

  localparam int WIDTH    = 18;
  localparam int NUM_CH   = 2;
  localparam int MAX_LOG2 = 3;
  localparam int RW       = $clog2(MAX_LOG2 + 1);
  localparam int DW       = WIDTH * NUM_CH;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] ratio_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_en;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          underrun;
  logic          clr_flags;

  int checks = 0;
  int errors = 0;
  int slot_n = 0;
  logic [DW:0] exp_q[$];

  interp_upsampler_n #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_LOG2(MAX_LOG2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ratio_sel (ratio_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_en    (out_en),
    .out_data  (out_data),
    .out_first (out_first),
    .underrun  (underrun),
    .clr_flags (clr_flags)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pk(input int a, input int b);
    return {WIDTH'(b), WIDTH'(a)};
  endfunction

  // value expected in slots 1..L-1 given the slot-0 value
  function automatic logic [DW-1:0] zs(input logic [DW-1:0] v);
`ifdef INTERP_UPS_HOLD_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  // scoreboard: expectation queued when out_en is driven, popped when the slot appears
  task automatic slot(input logic [DW-1:0] d, input logic f);
    logic [DW:0] e;
    exp_q.push_back({f, d});
    out_en = 1'b1;
    tick();
    out_en = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("slot%0d", slot_n), 64'({out_first, out_data}), 64'(e));
    slot_n++;
  endtask

  task automatic slot3(input logic [DW-1:0] d, input logic f);
    slot(d, f);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; ratio_sel = '0; in_valid = 1'b0; in_data = '0;
    out_en = 1'b0; clr_flags = 1'b0;

    // 1: reset with in_valid held high
    in_valid = 1'b1;
    in_data  = pk(1, 2);
    tick(); tick(); tick();
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_underrun", 64'(underrun), 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // 2: L=4, two words, out_en every third clock
    ratio_sel = 2'd2;
    push_word(pk(100, -100));
    push_word(pk(7, -7));
    slot3(pk(100, -100), 1'b1);
    slot3(zs(pk(100, -100)), 1'b0);
    slot3(zs(pk(100, -100)), 1'b0);
    slot3(zs(pk(100, -100)), 1'b0);
    slot3(pk(7, -7), 1'b1);
    slot3(zs(pk(7, -7)), 1'b0);
    slot3(zs(pk(7, -7)), 1'b0);
    slot3(zs(pk(7, -7)), 1'b0);
    chk("t2_underrun", 64'(underrun), 64'd0);

    // 3: L=2 with no data -> underrun, clear, then set-wins-over-clear
    ratio_sel = 2'd1;
    slot(pk(0, 0), 1'b1);
    chk("t3_underrun_set", 64'(underrun), 64'd1);
    slot(pk(0, 0), 1'b0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t3_underrun_clr", 64'(underrun), 64'd0);
    clr_flags = 1'b1;
    slot(pk(0, 0), 1'b1);
    clr_flags = 1'b0;
    chk("t3_set_wins", 64'(underrun), 64'd1);
    slot(pk(0, 0), 1'b0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;

    // 4: ratio change mid-frame takes effect at the next frame
    do_reset();
    ratio_sel = 2'd2;
    push_word(pk(11, 12));
    push_word(pk(21, 22));
    slot(pk(11, 12), 1'b1);
    push_word(pk(31, 32));
    slot(zs(pk(11, 12)), 1'b0);
    ratio_sel = 2'd0;
    slot(zs(pk(11, 12)), 1'b0);
    slot(zs(pk(11, 12)), 1'b0);
    slot(pk(21, 22), 1'b1);
    slot(pk(31, 32), 1'b1);
    chk("t4_no_underrun", 64'(underrun), 64'd0);

    // 5: FIFO full, third word waits for a pop (no push on full+pop)
    do_reset();
    ratio_sel = 2'd0;
    push_word(pk(1, -1));
    push_word(pk(2, -2));
    chk("t5_full_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = pk(3, -3);
    tick(); tick();
    chk("t5_still_full", 64'(in_ready), 64'd0);
    slot(pk(1, -1), 1'b1);
    chk("t5_ready_after_pop", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("t5_full_again", 64'(in_ready), 64'd0);
    slot(pk(2, -2), 1'b1);
    slot(pk(3, -3), 1'b1);
    chk("t5_no_underrun", 64'(underrun), 64'd0);
    slot(pk(0, 0), 1'b1);
    chk("t5_underrun", 64'(underrun), 64'd1);

    // 6: L=8 frame with a single word
    do_reset();
    ratio_sel = 2'd3;
    push_word(pk(55, 55));
    slot(pk(55, 55), 1'b1);
    for (int i = 1; i < 8; i++) slot(zs(pk(55, 55)), 1'b0);
    chk("t6_underrun", 64'(underrun), 64'd0);

    // 7: reset mid-frame flushes FIFO and phase
    ratio_sel = 2'd2;
    push_word(pk(9, 9));
    push_word(pk(8, 8));
    slot(pk(9, 9), 1'b1);
    slot(zs(pk(9, 9)), 1'b0);
    do_reset();
    chk("t7_out_data", 64'(out_data), 64'd0);
    chk("t7_out_first", 64'(out_first), 64'd0);
    chk("t7_in_ready", 64'(in_ready), 64'd1);
    ratio_sel = 2'd0;
    slot(pk(0, 0), 1'b1);
    chk("t7_flushed", 64'(underrun), 64'd1);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
